// File: rtl/add_sub_ovf_unit_if.sv
// Operand/result stream interface for add_sub_ovf_unit.
// The master side offers operand beats and accepts result beats.
interface add_sub_ovf_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_sub;
    logic             signed_mode;
    logic             sat_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             carry;

    modport master (
        output in_valid, a, b, op_sub, signed_mode, sat_mode, out_ready,
        input  in_ready, out_valid, result, overflow, carry
    );

    modport slave (
        input  in_valid, a, b, op_sub, signed_mode, sat_mode, out_ready,
        output in_ready, out_valid, result, overflow, carry
    );
endinterface

// File: rtl/add_sub_ovf_unit.sv
// Two-stage pipelined adder/subtractor with signed/unsigned overflow detection,
// optional saturation and a sticky overflow flag.
module add_sub_ovf_unit #(
    parameter int WIDTH  = 32,
    parameter int SAT_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_sub_ovf_unit_if.slave    bus,
    input  logic                 sticky_clr,
    output logic                 ovf_sticky
);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_sub;
    logic             s1_signed;
    logic             s1_sat;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_ovf;
    logic             s2_carry;

    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH-1:0] operand_b;
    logic [WIDTH:0]   raw;
    logic             raw_carry;
    logic             sgn_ovf;
    logic             uns_ovf;
    logic             ovf;
    logic [WIDTH-1:0] final_result;

    assign s2_adv      = !s2_valid || bus.out_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sub    <= 1'b0;
            s1_signed <= 1'b0;
            s1_sat    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a      <= bus.a;
                s1_b      <= bus.b;
                s1_sub    <= bus.op_sub;
                s1_signed <= bus.signed_mode;
                s1_sat    <= bus.sat_mode;
            end
        end
    end

    // Subtraction is a + ~b + 1, so carry-out of 1 means "no borrow".
    always_comb begin
        operand_b    = s1_sub ? ~s1_b : s1_b;
        raw          = {1'b0, s1_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, s1_sub};
        raw_carry    = raw[WIDTH];
        if (s1_sub)
            sgn_ovf = (s1_a[MSB] != s1_b[MSB]) && (raw[MSB] != s1_a[MSB]);
        else
            sgn_ovf = (s1_a[MSB] == s1_b[MSB]) && (raw[MSB] != s1_a[MSB]);
        uns_ovf      = s1_sub ? !raw_carry : raw_carry;
        ovf          = s1_signed ? sgn_ovf : uns_ovf;
        final_result = raw[MSB:0];
        if ((SAT_EN != 0) && s1_sat && ovf) begin
            if (s1_signed)
                final_result = s1_a[MSB] ? SMIN : SMAX;
            else
                final_result = s1_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_ovf    <= 1'b0;
            s2_carry  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= final_result;
                s2_ovf    <= ovf;
                s2_carry  <= raw_carry;
            end
        end
    end

    // A transferring overflow beat beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (s2_valid && bus.out_ready && s2_ovf)
            ovf_sticky <= 1'b1;
        else if (sticky_clr)
            ovf_sticky <= 1'b0;
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.overflow  = s2_ovf;
    assign bus.carry     = s2_carry;
endmodule

// File: tb/tb_add_sub_ovf_unit.sv
// Self-checking bench for add_sub_ovf_unit: directed corner cases plus
// randomized traffic checked against an arithmetic reference model.
module tb_add_sub_ovf_unit;
    logic clk;
    logic rst_n;
    logic sticky_clr;
    logic ovf_sticky;
    int   cyc;
    int   errors;
    int   checks;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        carry;
        int          t;
    } beat_t;

    beat_t q[$];
    logic  sticky_m;

    add_sub_ovf_unit_if #(.WIDTH(32)) bus ();

    add_sub_ovf_unit #(.WIDTH(32), .SAT_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sticky_clr (sticky_clr),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference computed with wide integer arithmetic rather than bit rules.
    function automatic beat_t model(input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, input logic sgn, input logic sat);
        beat_t       r;
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        longint      sr;
        longint      ur;
        logic [63:0] tmp;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sr = sub ? sa - sb : sa + sb;
        ur = sub ? ua - ub : ua + ub;
        tmp = ur;
        r.res   = tmp[31:0];
        r.carry = sub ? (ua >= ub) : (ur > 64'sd4294967295);
        if (sgn)
            r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        else
            r.ovf = sub ? (ua < ub) : (ur > 64'sd4294967295);
        if (sat && r.ovf) begin
            if (sgn)
                r.res = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            else
                r.res = sub ? 32'h0 : 32'hFFFF_FFFF;
        end
        r.t = 0;
        return r;
    endfunction

    // Every-cycle comparison against the queue of expected beats.
    always @(negedge clk) begin
        logic  exp_ov;
        logic  exp_ir;
        beat_t nb;
        if (!rst_n) begin
            checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
            checkOutput("rst_result", 64'(bus.result), 64'(0));
            checkOutput("rst_overflow", 64'(bus.overflow), 64'(0));
            checkOutput("rst_carry", 64'(bus.carry), 64'(0));
            checkOutput("rst_sticky", 64'(ovf_sticky), 64'(0));
            q.delete();
            sticky_m = 1'b0;
        end else begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
            exp_ir = (q.size() < 2) || bus.out_ready;
            checkOutput("in_ready", 64'(bus.in_ready), 64'(exp_ir));
            checkOutput("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            if (exp_ov) begin
                checkOutput("result", 64'(bus.result), 64'(q[0].res));
                checkOutput("overflow", 64'(bus.overflow), 64'(q[0].ovf));
                checkOutput("carry", 64'(bus.carry), 64'(q[0].carry));
            end
            checkOutput("sticky", 64'(ovf_sticky), 64'(sticky_m));
            if (exp_ov && bus.out_ready && q[0].ovf)
                sticky_m = 1'b1;
            else if (sticky_clr)
                sticky_m = 1'b0;
            if (exp_ov && bus.out_ready)
                void'(q.pop_front());
            if (bus.in_valid && exp_ir) begin
                nb   = model(bus.a, bus.b, bus.op_sub, bus.signed_mode, bus.sat_mode);
                nb.t = cyc;
                q.push_back(nb);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic sgn, input logic sat);
        bus.a           = a;
        bus.b           = b;
        bus.op_sub      = sub;
        bus.signed_mode = sgn;
        bus.sat_mode    = sat;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checkOutput("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic checkBeat(input string name, input logic [31:0] res,
                             input logic ovf, input logic carry);
        @(posedge clk);
        #1;
        checkOutput({name, "_valid"}, 64'(bus.out_valid), 64'(1));
        checkOutput({name, "_result"}, 64'(bus.result), 64'(res));
        checkOutput({name, "_overflow"}, 64'(bus.overflow), 64'(ovf));
        checkOutput({name, "_carry"}, 64'(bus.carry), 64'(carry));
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h1;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        beat_t m;
        cyc             = 0;
        errors          = 0;
        checks          = 0;
        sticky_m        = 1'b0;
        rst_n           = 1'b0;
        sticky_clr      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.op_sub      = 1'b0;
        bus.signed_mode = 1'b0;
        bus.sat_mode    = 1'b0;
        bus.out_ready   = 1'b1;

        m = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
        checkOutput("model_sadd_res", 64'(m.res), 64'h8000_0000);
        checkOutput("model_sadd_ovf", 64'(m.ovf), 64'(1));
        m = model(32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
        checkOutput("model_usub_sat", 64'(m.res), 64'(0));
        checkOutput("model_usub_carry", 64'(m.carry), 64'(0));
        m = model(32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1);
        checkOutput("model_ssub_sat", 64'(m.res), 64'h8000_0000);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 64'(bus.in_ready), 64'(1));

        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
        checkOutput("sticky_before_xfer", 64'(ovf_sticky), 64'(0));
        checkBeat("sadd_wrap", 32'h8000_0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("sticky_after_xfer", 64'(ovf_sticky), 64'(1));
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        checkOutput("sticky_cleared", 64'(ovf_sticky), 64'(0));

        applyStimulus(32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1);
        checkBeat("ssub_sat", 32'h8000_0000, 1'b1, 1'b1);
        applyStimulus(32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
        checkBeat("usub_sat", 32'h0, 1'b1, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        checkBeat("uadd_wrap", 32'h0, 1'b1, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
        checkBeat("sadd_noovf", 32'h0, 1'b0, 1'b1);
        applyStimulus(32'd7, 32'd5, 1'b1, 1'b0, 1'b0);
        checkBeat("usub_noovf", 32'd2, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        applyStimulus(32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        bus.a        = 32'd3;
        bus.b        = 32'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready", 64'(bus.in_ready), 64'(0));
        checkOutput("bp_result", 64'(bus.result), 64'(2));
        @(posedge clk);
        #1;
        checkOutput("bp_result_hold", 64'(bus.result), 64'(2));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bp_result_4", 64'(bus.result), 64'(4));
        @(posedge clk);
        #1;
        checkOutput("bp_result_6", 64'(bus.result), 64'(6));
        @(posedge clk);
        #1;
        checkOutput("bp_drained", 64'(bus.out_valid), 64'(0));

        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        checkOutput("sticky_pre_clear", 64'(ovf_sticky), 64'(0));
        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("sticky_set_wins", 64'(ovf_sticky), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("sticky_clr_alone", 64'(ovf_sticky), 64'(0));
        sticky_clr = 1'b0;

        bus.out_ready = 1'b0;
        applyStimulus(32'd10, 32'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'd20, 32'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full_before_reset", 64'(bus.out_valid), 64'(1));
        #1 rst_n = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("reset_immediate_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset_immediate_result", 64'(bus.result), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_midreset", 64'(bus.in_ready), 64'(1));
        checkOutput("no_beat_after_midreset", 64'(bus.out_valid), 64'(0));

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.a           = pickOperand();
            bus.b           = pickOperand();
            bus.op_sub      = 1'($urandom_range(0, 1));
            bus.signed_mode = 1'($urandom_range(0, 1));
            bus.sat_mode    = 1'($urandom_range(0, 1));
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            sticky_clr      = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        sticky_clr    = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("drain_queue_empty", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
